// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle control unit and the ALU control stage.
package cpu_ctrl_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH
  } state_t;

  localparam logic [2:0] OP_ADDI = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_SLTI = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_ANDI = 3'b100;
  localparam logic [2:0] OP_ORI  = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_RTYPE = 3'b111;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;
  localparam logic [1:0] ALU_OP_IMM  = 2'b11;

  localparam logic [1:0] SRC_B_REG  = 2'b00;
  localparam logic [1:0] SRC_B_ONE  = 2'b01;
  localparam logic [1:0] SRC_B_SEXT = 2'b10;
  localparam logic [1:0] SRC_B_ZEXT = 2'b11;

  localparam logic [5:0] FUNC_ADD = 6'd32;
  localparam logic [5:0] FUNC_SUB = 6'd34;
  localparam logic [5:0] FUNC_AND = 6'd36;
  localparam logic [5:0] FUNC_OR  = 6'd37;
  localparam logic [5:0] FUNC_SLT = 6'd42;
  localparam logic [5:0] FUNC_SLL = 6'd0;
  localparam logic [5:0] FUNC_SRL = 6'd2;

  function automatic logic func_legal(input logic [5:0] f);
    return (f == FUNC_ADD) || (f == FUNC_SUB) || (f == FUNC_AND) || (f == FUNC_OR) ||
           (f == FUNC_SLT) || (f == FUNC_SLL) || (f == FUNC_SRL);
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Moore output decode: state (plus mem_ready/zero gating) to datapath controls.
module ctrl_out_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [2:0]         opcode,
  input  logic               mem_ready,
  input  logic               zero,
  output logic               pc_write,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               i_or_d,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic               pc_src
);

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    alu_op     = ALU_OP_ADD;
    pc_src     = 1'b0;
    case (state_t'(state))
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_ONE;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = SRC_B_SEXT;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNC;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_IMM;
        // logical immediates zero-extend, arithmetic ones sign-extend
        alu_src_b = (opcode == OP_ANDI || opcode == OP_ORI) ? SRC_B_ZEXT : SRC_B_SEXT;
      end
      S_I_WB:     reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_SEXT;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_SUB;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle 16-bit datapath control: state sequencing, illegal-func detect,
// retired-instruction counter.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       opcode,
  input  logic [5:0]       func,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             pc_write,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             pc_src,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t state, state_nxt;
  logic   armed;
  logic   retire;

  // armed delays leaving RST by one edge so the first FETCH lands two edges
  // after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_RST;
      armed       <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (retire) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    illegal   = 1'b0;
    case (state)
      S_RST:   state_nxt = armed ? S_FETCH : S_RST;
      S_FETCH: if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_RTYPE) begin
          if (func_legal(func)) state_nxt = S_EXEC_R;
          else begin
            state_nxt = S_FETCH;
            illegal   = 1'b1;
          end
        end else if (opcode == OP_LW || opcode == OP_SW) state_nxt = S_MEM_ADDR;
        else if (opcode == OP_BEQ)                       state_nxt = S_BRANCH;
        else                                             state_nxt = S_EXEC_I;
      end
      S_EXEC_R:   state_nxt = S_R_WB;
      S_EXEC_I:   state_nxt = S_I_WB;
      S_MEM_ADDR: state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WR: begin
        if (mem_ready) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      default: state_nxt = S_RST;
    endcase
  end

  ctrl_out_decode u_dec (
    .state      (state),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed per-cycle vectors for multicycle_control; a second narrow-counter
// instance shares the stimulus to exercise counter wrap.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] opcode;
  logic [5:0] func;
  logic mem_ready, zero;

  logic pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst, mem_to_reg;
  logic alu_src_a, pc_src, illegal;
  logic [1:0] alu_src_b, alu_op;
  logic [15:0] instr_count;

  logic pw2, irw2, mr2, mw2, iod2, rw2, rd2, m2r2, asa2, psrc2, ill2;
  logic [1:0] asb2, aop2;
  logic [1:0] cnt2;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .illegal(illegal), .instr_count(instr_count)
  );

  multicycle_control #(.CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .mem_ready(mem_ready), .zero(zero),
    .pc_write(pw2), .ir_write(irw2), .mem_read(mr2), .mem_write(mw2),
    .i_or_d(iod2), .reg_write(rw2), .reg_dst(rd2), .mem_to_reg(m2r2),
    .alu_src_a(asa2), .alu_src_b(asb2), .alu_op(aop2), .pc_src(psrc2),
    .illegal(ill2), .instr_count(cnt2)
  );

  // {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst,
  //  mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src, illegal}
  logic [14:0] outv;
  assign outv = {pc_write, ir_write, mem_read, mem_write, i_or_d, reg_write, reg_dst,
                 mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, illegal};

  localparam logic [14:0] E_RST     = 15'b0_0_0_0_0_0_0_0_0_00_00_0_0;
  localparam logic [14:0] E_FETCH   = 15'b1_1_1_0_0_0_0_0_0_01_00_0_0;
  localparam logic [14:0] E_FETCH_W = 15'b0_0_1_0_0_0_0_0_0_01_00_0_0;
  localparam logic [14:0] E_DEC     = 15'b0_0_0_0_0_0_0_0_0_10_00_0_0;
  localparam logic [14:0] E_DEC_ILL = 15'b0_0_0_0_0_0_0_0_0_10_00_0_1;
  localparam logic [14:0] E_EXEC_R  = 15'b0_0_0_0_0_0_0_0_1_00_10_0_0;
  localparam logic [14:0] E_R_WB    = 15'b0_0_0_0_0_1_1_0_0_00_00_0_0;
  localparam logic [14:0] E_EXI_Z   = 15'b0_0_0_0_0_0_0_0_1_11_11_0_0;
  localparam logic [14:0] E_EXI_S   = 15'b0_0_0_0_0_0_0_0_1_10_11_0_0;
  localparam logic [14:0] E_I_WB    = 15'b0_0_0_0_0_1_0_0_0_00_00_0_0;
  localparam logic [14:0] E_MADDR   = 15'b0_0_0_0_0_0_0_0_1_10_00_0_0;
  localparam logic [14:0] E_MRD     = 15'b0_0_1_0_1_0_0_0_0_00_00_0_0;
  localparam logic [14:0] E_MWB     = 15'b0_0_0_0_0_1_0_1_0_00_00_0_0;
  localparam logic [14:0] E_MWR     = 15'b0_0_0_1_1_0_0_0_0_00_00_0_0;
  localparam logic [14:0] E_BR_T    = 15'b1_0_0_0_0_0_0_0_1_00_01_1_0;
  localparam logic [14:0] E_BR_N    = 15'b0_0_0_0_0_0_0_0_1_00_01_1_0;

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  fn;
    logic        mr;
    logic        z;
    logic [14:0] exp;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic [2:0] op, input logic [5:0] fn, input logic mr,
                     input logic z, input logic [14:0] exp, input logic [15:0] cnt);
    vec_t v;
    v.op = op; v.fn = fn; v.mr = mr; v.z = z; v.exp = exp; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [14:0] e, input logic [15:0] c);
    logic [1:0] c2;
    c2 = c[1:0];
    checks++;
    if (outv !== e) begin
      errors++;
      $display("FAIL %s outputs got %b want %b", nm, outv, e);
    end
    checks++;
    if (instr_count !== c) begin
      errors++;
      $display("FAIL %s instr_count got %0d want %0d", nm, instr_count, c);
    end
    checks++;
    if (cnt2 !== c2) begin
      errors++;
      $display("FAIL %s wrap_count got %0d want %0d", nm, cnt2, c2);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [5:0] fn, input logic mr, input logic z);
    @(negedge clk);
    opcode = op; func = fn; mem_ready = mr; zero = z;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = 3'b000; func = 6'd0; mem_ready = 1'b1; zero = 1'b0;

    // R-type add
    add(3'b111, 6'd32, 1, 0, E_FETCH,  0);
    add(3'b111, 6'd32, 1, 0, E_DEC,    0);
    add(3'b111, 6'd32, 1, 0, E_EXEC_R, 0);
    add(3'b111, 6'd32, 1, 0, E_R_WB,   0);
    // lw with three wait cycles in MEM_RD: 8 cycles
    add(3'b001, 6'd0, 1, 0, E_FETCH, 1);
    add(3'b001, 6'd0, 1, 0, E_DEC,   1);
    add(3'b001, 6'd0, 1, 0, E_MADDR, 1);
    add(3'b001, 6'd0, 0, 0, E_MRD,   1);
    add(3'b001, 6'd0, 0, 0, E_MRD,   1);
    add(3'b001, 6'd0, 0, 0, E_MRD,   1);
    add(3'b001, 6'd0, 1, 0, E_MRD,   1);
    add(3'b001, 6'd0, 1, 0, E_MWB,   1);
    // beq taken / not taken
    add(3'b110, 6'd0, 1, 1, E_FETCH, 2);
    add(3'b110, 6'd0, 1, 1, E_DEC,   2);
    add(3'b110, 6'd0, 1, 1, E_BR_T,  2);
    add(3'b110, 6'd0, 1, 0, E_FETCH, 3);
    add(3'b110, 6'd0, 1, 0, E_DEC,   3);
    add(3'b110, 6'd0, 1, 0, E_BR_N,  3);
    // ori, slti
    add(3'b101, 6'd0, 1, 0, E_FETCH, 4);
    add(3'b101, 6'd0, 1, 0, E_DEC,   4);
    add(3'b101, 6'd0, 1, 0, E_EXI_Z, 4);
    add(3'b101, 6'd0, 1, 0, E_I_WB,  4);
    add(3'b010, 6'd0, 1, 0, E_FETCH, 5);
    add(3'b010, 6'd0, 1, 0, E_DEC,   5);
    add(3'b010, 6'd0, 1, 0, E_EXI_S, 5);
    add(3'b010, 6'd0, 1, 0, E_I_WB,  5);
    // illegal R-type func 7: no count, straight back to FETCH
    add(3'b111, 6'd7, 1, 0, E_FETCH,   6);
    add(3'b111, 6'd7, 1, 0, E_DEC_ILL, 6);
    // sw with two wait cycles; opcode changes mid-stall must be ignored
    add(3'b011, 6'd0, 1, 0, E_FETCH, 6);
    add(3'b011, 6'd0, 1, 0, E_DEC,   6);
    add(3'b011, 6'd0, 1, 0, E_MADDR, 6);
    add(3'b011, 6'd0, 0, 0, E_MWR,   6);
    add(3'b110, 6'd7, 0, 0, E_MWR,   6);
    add(3'b001, 6'd0, 1, 0, E_MWR,   6);
    // FETCH stalled on memory
    add(3'b000, 6'd0, 0, 0, E_FETCH_W, 7);
    add(3'b000, 6'd0, 0, 0, E_FETCH_W, 7);

    // power-on reset, then release and count edges to first FETCH
    repeat (2) @(negedge clk);
    #1 chk("reset_held", E_RST, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("release_edge0", E_RST, 0);
    @(negedge clk);
    #1 chk("release_edge1", E_RST, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].fn, vecs[i].mr, vecs[i].z);
      chk($sformatf("vec%0d", i), vecs[i].exp, vecs[i].cnt);
    end

    // reset asserted in the middle of a stalled sw
    drive(3'b011, 6'd0, 1, 0); chk("sw2_fetch", E_FETCH, 7);
    drive(3'b011, 6'd0, 1, 0); chk("sw2_dec",   E_DEC,   7);
    drive(3'b011, 6'd0, 1, 0); chk("sw2_maddr", E_MADDR, 7);
    drive(3'b011, 6'd0, 0, 0); chk("sw2_wr",    E_MWR,   7);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", E_RST, 0);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b1;
    #1 chk("rerelease_edge0", E_RST, 0);
    @(negedge clk);
    #1 chk("rerelease_edge1", E_RST, 0);
    @(negedge clk);
    #1 chk("rerelease_fetch", E_FETCH, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
